// File: rtl/md_pkg.sv
// Shared types for the market-data stream path: the decoded order record,
// the transmit framer state encoding and the heartbeat message type.
package md_pkg;

   typedef struct packed {
      logic [7:0]  msg_type;
      logic [31:0] symbol;
      logic [31:0] price_q16_16;
      logic [31:0] qty;
   } md_record_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_BEAT0,
      ST_BEAT1,
      ST_HB
   } md_tx_state_e;

   localparam logic [7:0] MSG_HEARTBEAT = 8'h48;
   localparam int         SEQ_W         = 24;
   localparam int         HB_CNT_W      = 20;

endpackage

// File: rtl/md_heartbeat_timer.sv
// Idle-cycle counter for the transmit framer; fire_o pulses in the cycle the
// count reaches HB_PERIOD-1 while the link is still idle.
import md_pkg::*;

module md_heartbeat_timer #(
   parameter int HB_PERIOD = 1000
) (
   input  logic clk,
   input  logic rst,
   input  logic run_i,
   input  logic clear_i,
   output logic fire_o
);

   localparam logic [HB_CNT_W-1:0] Threshold = HB_CNT_W'(HB_PERIOD - 1);

   logic [HB_CNT_W-1:0] count_q, count_d;

   assign fire_o = run_i && (count_q == Threshold);

   // Any interruption of idleness restarts the count from zero.
   always_comb begin
      count_d = count_q;
      if (clear_i || !run_i || fire_o) begin
         count_d = '0;
      end else begin
         count_d = count_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/md_packet_tx.sv
// Transmit framer: stamps each order record with a 24-bit sequence number and
// emits a two-beat 64-bit AXI-stream packet. Optional idle heartbeat is built
// in when MD_PACKET_TX_HEARTBEAT_EN is defined.
import md_pkg::*;

module md_packet_tx #(
   parameter int WIDTH     = 64,
   parameter int HB_PERIOD = 1000
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               rec_valid,
   output logic               rec_ready,
   input  logic [103:0]       rec_data,
   output logic [WIDTH-1:0]   master_tdata,
   output logic [WIDTH/8-1:0] master_byteEnable,
   output logic               master_tvalid,
   output logic               master_tlast,
   input  logic               master_tready,
   output logic [SEQ_W-1:0]   seq_out
);

   if (WIDTH != 64) begin : g_bad_width
      $error("md_packet_tx supports only WIDTH=64");
   end
   if (HB_PERIOD < 2 || HB_PERIOD > 1048576) begin : g_bad_hb_period
      $error("md_packet_tx HB_PERIOD must be in 2..2^20");
   end

   md_tx_state_e      state_q, state_d;
   md_record_t        hold_q, hold_d;
   md_record_t        cur_q, cur_d;
   md_record_t        rec_in;
   logic              hold_valid_q, hold_valid_d;
   logic [SEQ_W-1:0]  seq_q, seq_d;
   logic [SEQ_W-1:0]  cur_seq_q, cur_seq_d;
   logic              accept;
   logic              fsm_free;
   logic              hb_fire;

   assign rec_in            = md_record_t'(rec_data);
   assign rec_ready         = !hold_valid_q;
   assign accept            = rec_valid && !hold_valid_q;
   assign master_tvalid     = (state_q != ST_IDLE);
   assign master_byteEnable = '1;
   assign seq_out           = seq_q;

`ifdef MD_PACKET_TX_HEARTBEAT_EN
   logic idle_run;
   logic last_handshake;

   assign idle_run       = (state_q == ST_IDLE) && !hold_valid_q && !accept;
   assign last_handshake = master_tvalid && master_tready && master_tlast;

   md_heartbeat_timer #(
      .HB_PERIOD(HB_PERIOD)
   ) u_hb_timer (
      .clk    (clk),
      .rst    (rst),
      .run_i  (idle_run),
      .clear_i(last_handshake),
      .fire_o (hb_fire)
   );
`else
   assign hb_fire = 1'b0;
`endif

   always_comb begin
      fsm_free = 1'b0;
      case (state_q)
         ST_IDLE:         fsm_free = 1'b1;
         ST_BEAT1, ST_HB: fsm_free = master_tready;
         default:         fsm_free = 1'b0;
      endcase
   end

   // When the FSM frees up, a waiting hold record goes first and a record
   // accepted in the same cycle drops into the hold slot it vacates.
   always_comb begin
      state_d      = state_q;
      hold_d       = hold_q;
      hold_valid_d = hold_valid_q;
      cur_d        = cur_q;
      cur_seq_d    = cur_seq_q;
      seq_d        = seq_q;

      if (state_q == ST_BEAT0 && master_tready) begin
         state_d = ST_BEAT1;
      end

      if (fsm_free) begin
         if (hold_valid_q) begin
            cur_d        = hold_q;
            cur_seq_d    = seq_q;
            seq_d        = seq_q + 1'b1;
            state_d      = ST_BEAT0;
            hold_valid_d = accept;
            if (accept) begin
               hold_d = rec_in;
            end
         end else if (accept) begin
            cur_d     = rec_in;
            cur_seq_d = seq_q;
            seq_d     = seq_q + 1'b1;
            state_d   = ST_BEAT0;
         end else if (hb_fire) begin
            cur_seq_d = seq_q;
            seq_d     = seq_q + 1'b1;
            state_d   = ST_HB;
         end else begin
            state_d = ST_IDLE;
         end
      end else if (accept) begin
         hold_d       = rec_in;
         hold_valid_d = 1'b1;
      end
   end

   // Beat contents depend only on state and cur so they hold under backpressure.
   always_comb begin
      master_tdata = '0;
      master_tlast = 1'b0;
      case (state_q)
         ST_BEAT0: master_tdata = {cur_q.msg_type, cur_q.symbol, cur_seq_q};
         ST_BEAT1: begin
            master_tdata = {cur_q.price_q16_16, cur_q.qty};
            master_tlast = 1'b1;
         end
         ST_HB: begin
            master_tdata = {MSG_HEARTBEAT, 32'h0, cur_seq_q};
            master_tlast = 1'b1;
         end
         default: begin
            master_tdata = '0;
            master_tlast = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         hold_q       <= '0;
         hold_valid_q <= 1'b0;
         cur_q        <= '0;
         cur_seq_q    <= '0;
         seq_q        <= '0;
      end else begin
         state_q      <= state_d;
         hold_q       <= hold_d;
         hold_valid_q <= hold_valid_d;
         cur_q        <= cur_d;
         cur_seq_q    <= cur_seq_d;
         seq_q        <= seq_d;
      end
   end

endmodule

// File: tb/tb_md_packet_tx.sv
// Self-checking bench for md_packet_tx: a scoreboard queue of expected beats
// is filled on each accepted record and drained on each stream handshake.
`timescale 1ns/1ps

module tb_md_packet_tx;
   import md_pkg::*;

`ifdef MD_PACKET_TX_HEARTBEAT_EN
   localparam int HbPeriod = 8;
`else
   localparam int HbPeriod = 1000;
`endif

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         recValid = 1'b0;
   logic         recReady;
   logic [103:0] recData = '0;
   logic [63:0]  masterTdata;
   logic [7:0]   masterByteEnable;
   logic         masterTvalid;
   logic         masterTlast;
   logic         masterTready = 1'b1;
   logic [23:0]  seqOut;

   int passCount  = 0;
   int checkCount = 0;

   // Expected beats, {tlast, tdata}, in transmit order.
   logic [64:0] expQ[$];
   logic [23:0] expSeq = '0;

   md_packet_tx #(
      .WIDTH    (64),
      .HB_PERIOD(HbPeriod)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .rec_valid        (recValid),
      .rec_ready        (recReady),
      .rec_data         (recData),
      .master_tdata     (masterTdata),
      .master_byteEnable(masterByteEnable),
      .master_tvalid    (masterTvalid),
      .master_tlast     (masterTlast),
      .master_tready    (masterTready),
      .seq_out          (seqOut)
   );

   always #5 clk = ~clk;

   function automatic logic [103:0] mkRec(input logic [7:0] t, input logic [31:0] s,
                                          input logic [31:0] p, input logic [31:0] q);
      return {t, s, p, q};
   endfunction

   // Reference model of the packet layout: header beat then price/qty beat.
   function automatic void pushRecord(input logic [103:0] r);
      expQ.push_back({1'b0, r[103:96], r[95:64], expSeq});
      expQ.push_back({1'b1, r[63:32], r[31:0]});
      expSeq = expSeq + 24'd1;
   endfunction

   // Short reset pulse so each scenario starts from a known, idle framer.
   task automatic applyStimulus_reset();
      @(posedge clk); #1;
      rst          = 1'b1;
      recValid     = 1'b0;
      masterTready = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      expQ.delete();
      expSeq = '0;
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; recValid = 1'b0; masterTready = 1'b1;
      repeat (2) @(negedge clk);
      checkCount++;
      if (recReady !== 1'b1) $display("[TB] FAIL reset_rec_ready got=%b exp=1", recReady);
      else passCount++;
      checkCount++;
      if (masterTvalid !== 1'b0) $display("[TB] FAIL reset_tvalid got=%b exp=0", masterTvalid);
      else passCount++;
      checkCount++;
      if (masterTlast !== 1'b0) $display("[TB] FAIL reset_tlast got=%b exp=0", masterTlast);
      else passCount++;
      checkCount++;
      if (masterTdata !== 64'h0) $display("[TB] FAIL reset_tdata got=%h exp=0", masterTdata);
      else passCount++;
      checkCount++;
      if (seqOut !== 24'h0) $display("[TB] FAIL reset_seq got=%h exp=0", seqOut);
      else passCount++;
      checkCount++;
      if (masterByteEnable !== 8'hFF) $display("[TB] FAIL reset_byte_enable got=%h exp=ff", masterByteEnable);
      else passCount++;
      rst = 1'b0;
      expQ.delete();
      expSeq = '0;
      @(posedge clk); #1;
   endtask

   task automatic test_single();
      logic [103:0] rec;
      logic [64:0]  exp;
      int sent = 0;
      int acceptCyc = -1;
      int firstValidCyc = -1;
      applyStimulus_reset();
      rec = mkRec(8'h54, 32'h4141504C, 32'h00010000, 32'd100);
      expQ.push_back({1'b0, 64'h544141504C000000});
      expQ.push_back({1'b1, 64'h0001000000000064});
      recValid = 1'b1; recData = rec;
      for (int cyc = 0; cyc < 20 && (sent < 1 || expQ.size() > 0); cyc++) begin
         @(negedge clk);
         if (masterTvalid && firstValidCyc < 0) firstValidCyc = cyc;
         if (masterTvalid && masterTready) begin
            checkCount++;
            if (expQ.size() == 0) begin
               $display("[TB] FAIL single_beat unexpected got=%h", masterTdata);
            end else begin
               exp = expQ.pop_front();
               if ({masterTlast, masterTdata} !== exp)
                  $display("[TB] FAIL single_beat got=%b_%h exp=%b_%h", masterTlast, masterTdata, exp[64], exp[63:0]);
               else passCount++;
            end
         end
         if (recValid && recReady) begin
            sent++;
            acceptCyc = cyc;
         end
         @(posedge clk); #1;
         recValid = (sent < 1);
      end
      checkCount++;
      if (firstValidCyc - acceptCyc !== 1)
         $display("[TB] FAIL single_latency got=%0d exp=1", firstValidCyc - acceptCyc);
      else passCount++;
      checkCount++;
      if (expQ.size() != 0) $display("[TB] FAIL single_done left=%0d exp=0", expQ.size());
      else passCount++;
   endtask

   task automatic test_back_to_back();
      logic [103:0] recs[4];
      logic [64:0]  exp;
      int sent = 0;
      int beats = 0;
      int gaps = 0;
      applyStimulus_reset();
      for (int i = 0; i < 4; i++)
         recs[i] = mkRec(8'h41 + 8'(i), 32'hA0000000 + 32'(i), 32'(i * 3 + 1), 32'(i * 7 + 2));
      recValid = 1'b1; recData = recs[0];
      for (int cyc = 0; cyc < 40 && (sent < 4 || expQ.size() > 0); cyc++) begin
         @(negedge clk);
         if (beats > 0 && beats < 8 && !masterTvalid) gaps++;
         if (masterTvalid && masterTready) begin
            beats++;
            checkCount++;
            if (expQ.size() == 0) begin
               $display("[TB] FAIL b2b_beat unexpected got=%h", masterTdata);
            end else begin
               exp = expQ.pop_front();
               if ({masterTlast, masterTdata} !== exp)
                  $display("[TB] FAIL b2b_beat got=%b_%h exp=%b_%h", masterTlast, masterTdata, exp[64], exp[63:0]);
               else passCount++;
            end
         end
         if (recValid && recReady) begin
            pushRecord(recs[sent]);
            sent++;
         end
         @(posedge clk); #1;
         recValid = (sent < 4);
         if (sent < 4) recData = recs[sent];
      end
      checkCount++;
      if (gaps != 0 || beats != 8)
         $display("[TB] FAIL b2b_no_gaps got gaps=%0d beats=%0d exp gaps=0 beats=8", gaps, beats);
      else passCount++;
      checkCount++;
      if (seqOut !== 24'd4) $display("[TB] FAIL b2b_seq_out got=%h exp=4", seqOut);
      else passCount++;
   endtask

   task automatic test_backpressure();
      logic [103:0] recs[3];
      logic [64:0]  exp;
      int sent = 0;
      int stalls = 0;
      int unstable = 0;
      applyStimulus_reset();
      for (int i = 0; i < 3; i++)
         recs[i] = mkRec(8'h51, 32'h53594D00 + 32'(i), 32'h00020000 + 32'(i), 32'(50 + i));
      masterTready = 1'b0;
      recValid = 1'b1; recData = recs[0];
      for (int cyc = 0; cyc < 60 && (sent < 3 || expQ.size() > 0); cyc++) begin
         @(negedge clk);
         if (masterTvalid && !masterTready) begin
            stalls++;
            if (expQ.size() == 0 || masterTdata !== expQ[0][63:0] || masterTlast !== 1'b0) unstable++;
            if (stalls == 10) begin
               checkCount++;
               if (recReady !== 1'b0) $display("[TB] FAIL bp_rec_ready got=%b exp=0", recReady);
               else passCount++;
               checkCount++;
               if (sent != 2) $display("[TB] FAIL bp_in_flight got=%0d exp=2", sent);
               else passCount++;
            end
         end
         if (masterTvalid && masterTready) begin
            checkCount++;
            if (expQ.size() == 0) begin
               $display("[TB] FAIL bp_beat unexpected got=%h", masterTdata);
            end else begin
               exp = expQ.pop_front();
               if ({masterTlast, masterTdata} !== exp)
                  $display("[TB] FAIL bp_beat got=%b_%h exp=%b_%h", masterTlast, masterTdata, exp[64], exp[63:0]);
               else passCount++;
            end
         end
         if (recValid && recReady) begin
            pushRecord(recs[sent]);
            sent++;
         end
         @(posedge clk); #1;
         masterTready = (stalls >= 10);
         recValid = (sent < 3);
         if (sent < 3) recData = recs[sent];
      end
      checkCount++;
      if (unstable != 0 || stalls != 10)
         $display("[TB] FAIL bp_stable got unstable=%0d stalls=%0d exp unstable=0 stalls=10", unstable, stalls);
      else passCount++;
      checkCount++;
      if (sent != 3 || expQ.size() != 0)
         $display("[TB] FAIL bp_no_loss got sent=%0d left=%0d exp sent=3 left=0", sent, expQ.size());
      else passCount++;
      masterTready = 1'b1;
   endtask

   task automatic test_wrap();
      logic [103:0] recs[2];
      logic [64:0]  exp;
      logic [23:0]  seenSeq[$];
      int sent = 0;
      applyStimulus_reset();
      recs[0] = mkRec(8'h57, 32'h57524150, 32'h1, 32'h2);
      recs[1] = mkRec(8'h58, 32'h57524151, 32'h3, 32'h4);
      force dut.seq_q = 24'hFFFFFF;
      @(posedge clk);
      @(negedge clk);
      release dut.seq_q;
      checkCount++;
      if (seqOut !== 24'hFFFFFF) $display("[TB] FAIL wrap_preset got=%h exp=ffffff", seqOut);
      else passCount++;
      expSeq = 24'hFFFFFF;
      @(posedge clk); #1;
      recValid = 1'b1; recData = recs[0];
      for (int cyc = 0; cyc < 30 && (sent < 2 || expQ.size() > 0); cyc++) begin
         @(negedge clk);
         if (masterTvalid && masterTready) begin
            if (!masterTlast) seenSeq.push_back(masterTdata[23:0]);
            checkCount++;
            if (expQ.size() == 0) begin
               $display("[TB] FAIL wrap_beat unexpected got=%h", masterTdata);
            end else begin
               exp = expQ.pop_front();
               if ({masterTlast, masterTdata} !== exp)
                  $display("[TB] FAIL wrap_beat got=%b_%h exp=%b_%h", masterTlast, masterTdata, exp[64], exp[63:0]);
               else passCount++;
            end
         end
         if (recValid && recReady) begin
            pushRecord(recs[sent]);
            sent++;
         end
         @(posedge clk); #1;
         recValid = (sent < 2);
         if (sent < 2) recData = recs[sent];
      end
      checkCount++;
      if (seenSeq.size() != 2 || seenSeq[0] !== 24'hFFFFFF || seenSeq[1] !== 24'h000000)
         $display("[TB] FAIL wrap_seq got n=%0d first=%h second=%h exp ffffff then 000000",
                  seenSeq.size(), (seenSeq.size() > 0) ? seenSeq[0] : 24'hx,
                  (seenSeq.size() > 1) ? seenSeq[1] : 24'hx);
      else passCount++;
      checkCount++;
      if (seqOut !== 24'd1) $display("[TB] FAIL wrap_seq_out got=%h exp=1", seqOut);
      else passCount++;
   endtask

   task automatic test_reset_mid_packet();
      logic [103:0] rec;
      logic [64:0]  exp;
      int sent = 0;
      bit hitBeat1 = 0;
      applyStimulus_reset();
      rec = mkRec(8'h52, 32'h52535431, 32'h00030000, 32'd9);
      recValid = 1'b1; recData = rec;
      for (int cyc = 0; cyc < 20 && !hitBeat1; cyc++) begin
         @(negedge clk);
         if (masterTvalid && masterTlast) begin
            hitBeat1 = 1;
         end else begin
            if (masterTvalid && masterTready) begin
               checkCount++;
               exp = (expQ.size() > 0) ? expQ.pop_front() : 65'h0;
               if ({masterTlast, masterTdata} !== exp)
                  $display("[TB] FAIL rstmid_beat0 got=%b_%h exp=%b_%h", masterTlast, masterTdata, exp[64], exp[63:0]);
               else passCount++;
            end
            if (recValid && recReady) begin
               pushRecord(rec);
               sent++;
            end
            @(posedge clk); #1;
            recValid = (sent < 1);
         end
      end
      rst = 1'b1;
      #1;
      checkCount++;
      if (!hitBeat1 || masterTvalid !== 1'b0 || masterTlast !== 1'b0 || masterTdata !== 64'h0 || seqOut !== 24'h0)
         $display("[TB] FAIL rstmid_clear got hit=%0d tvalid=%b tlast=%b tdata=%h seq=%h exp 1 0 0 0 0",
                  hitBeat1, masterTvalid, masterTlast, masterTdata, seqOut);
      else passCount++;
      @(negedge clk);
      rst = 1'b0;
      expQ.delete();
      expSeq = '0;
      sent = 0;
      rec = mkRec(8'h53, 32'h52535432, 32'h00040000, 32'd11);
      @(posedge clk); #1;
      recValid = 1'b1; recData = rec;
      for (int cyc = 0; cyc < 20 && (sent < 1 || expQ.size() > 0); cyc++) begin
         @(negedge clk);
         if (masterTvalid && masterTready) begin
            checkCount++;
            if (expQ.size() == 0) begin
               $display("[TB] FAIL rstmid_after unexpected got=%h", masterTdata);
            end else begin
               exp = expQ.pop_front();
               if ({masterTlast, masterTdata} !== exp)
                  $display("[TB] FAIL rstmid_after got=%b_%h exp=%b_%h", masterTlast, masterTdata, exp[64], exp[63:0]);
               else passCount++;
            end
         end
         if (recValid && recReady) begin
            pushRecord(rec);
            sent++;
         end
         @(posedge clk); #1;
         recValid = (sent < 1);
      end
      checkCount++;
      if (sent != 1 || expQ.size() != 0)
         $display("[TB] FAIL rstmid_done got sent=%0d left=%0d exp 1 0", sent, expQ.size());
      else passCount++;
   endtask

`ifdef MD_PACKET_TX_HEARTBEAT_EN
   task automatic test_heartbeat();
      logic [103:0] rec;
      int waited = 0;
      // Release reset on a falling edge so the idle count is exactly known.
      @(posedge clk); #1;
      rst = 1'b1; recValid = 1'b0; masterTready = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      for (int cyc = 1; cyc <= 20 && waited == 0; cyc++) begin
         @(negedge clk);
         if (masterTvalid) waited = cyc;
      end
      checkCount++;
      if (waited != HbPeriod) $display("[TB] FAIL hb_delay got=%0d exp=%0d", waited, HbPeriod);
      else passCount++;
      checkCount++;
      if (masterTdata !== 64'h4800000000000000 || masterTlast !== 1'b1)
         $display("[TB] FAIL hb_beat got=%b_%h exp=1_4800000000000000", masterTlast, masterTdata);
      else passCount++;
      @(negedge clk);
      checkCount++;
      if (masterTvalid !== 1'b0 || seqOut !== 24'd1)
         $display("[TB] FAIL hb_single got tvalid=%b seq=%h exp 0 1", masterTvalid, seqOut);
      else passCount++;

      rec = mkRec(8'h54, 32'h48424F46, 32'h5, 32'h6);
      @(posedge clk); #1;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      repeat (HbPeriod - 1) @(posedge clk);
      #1;
      recValid = 1'b1; recData = rec;
      @(posedge clk); #1;
      recValid = 1'b0;
      @(negedge clk);
      checkCount++;
      if (masterTdata !== 64'h5448424F46000000 || masterTlast !== 1'b0)
         $display("[TB] FAIL hb_suppress got=%b_%h exp=0_5448424f46000000", masterTlast, masterTdata);
      else passCount++;
      @(negedge clk);
      checkCount++;
      if (masterTdata !== 64'h0000000500000006 || masterTlast !== 1'b1)
         $display("[TB] FAIL hb_suppress_beat1 got=%b_%h exp=1_0000000500000006", masterTlast, masterTdata);
      else passCount++;
      @(posedge clk); #1;
   endtask
`endif

   initial begin
      #400000;
      $display("[TB] FAIL watchdog timeout");
      $fatal(1, "[TB] simulation did not finish");
   end

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_backpressure();
      test_wrap();
      test_reset_mid_packet();
`ifdef MD_PACKET_TX_HEARTBEAT_EN
      test_heartbeat();
`endif
      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule

// File: doc/md_packet_tx.md
# md_packet_tx

Transmit-side framer for the market-data AXI-stream path. Accepts one decoded order record per valid/ready handshake, stamps it with a 24-bit sequence number and serializes it into a two-beat, 64-bit AXI-stream packet. This is the packet layout the inbound cut-through filter parses. The block feeds loopback and stimulus generation, and serves as the outbound order/quote path toward the MAC.

## Interface
Parameters:
- WIDTH, 64: stream data width; only 64 is supported.
- HB_PERIOD, 1000: idle cycles before a heartbeat is sent; used only with the heartbeat feature; legal range 2..2^20.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- rec_valid  in  1  record offered.
- rec_ready  out  1  record can be taken.
- rec_data  in  104  md_record_t {msg_type[7:0], symbol[31:0], price_q16_16[31:0], qty[31:0]}, MSB first.
- master_tdata  out  WIDTH  stream data.
- master_byteEnable  out  WIDTH/8  byte enables; always 8'hFF.
- master_tvalid  out  1  beat valid.
- master_tlast  out  1  last beat of the packet.
- master_tready  in  1  downstream ready.
- seq_out  out  24  sequence number that the next packet will carry.

## Operation
Registers:
- hold: one record plus hold_valid.
- cur: the record being sent plus its sequence number.
- state: IDLE, BEAT0, BEAT1, or HB.
- seq: 24-bit counter.

Rules:
- rec_ready = !hold_valid, driven straight from the register.
- An accepted record loads straight into cur, with cur.seq = seq, when the FSM is free at that edge. Free means IDLE, BEAT1 with master_tready, or HB with master_tready. The FSM goes to BEAT0. Otherwise the record loads into hold.
- On leaving BEAT1 or HB, a pending hold takes priority over a new record. The new record then goes into hold, because hold frees at the same edge.
- BEAT0: tdata = {msg_type, symbol, cur.seq[23:0]}, tlast = 0.
- BEAT1: tdata = {price_q16_16, qty}, tlast = 1.
- master_tvalid = (state != IDLE).
- tdata and tlast are decoded from state and cur only, so they stay stable while tvalid=1 and tready=0.
- Transitions:
  - BEAT0 → BEAT1 on tready.
  - BEAT1 → BEAT0 on tready, if a record is available.
  - BEAT1 → IDLE on tready, if no record is available.
- seq increments by 1 at each load into cur. It wraps 24'hFFFFFF → 0.
- No fields are validated; msg_type and symbol pass through unchanged.

## Timing
- Reset values: state IDLE, hold_valid 0, seq 0, cur 0. Resulting outputs: rec_ready 1, master_tvalid 0, master_tlast 0, master_tdata 0, seq_out 0. master_byteEnable is constant 8'hFF.
- Latency: a record accepted at edge E while IDLE gives beat 0 valid right after E, i.e. 1 cycle.
- Throughput: one packet per 2 cycles with tready held at 1, with no idle cycle between packets.
- Backpressure: tvalid, once high, stays high until the handshake. With tready=0, hold fills and rec_ready drops. At most 2 records are in flight.
- Reset mid-packet: outputs clear immediately. The truncated packet is not completed, and the next packet starts with seq 0.

## Configuration
Macro: MD_PACKET_TX_HEARTBEAT_EN.

With the macro defined:
- An idle counter runs while state is IDLE, hold_valid is 0 and no record is accepted.
- When the counter reaches HB_PERIOD-1, the FSM enters HB. HB sends a single beat {8'h48, 32'h0, seq} with tlast=1, and consumes one sequence number.
- A record accepted in the cycle the counter hits its threshold wins: no heartbeat is sent and the counter clears.
- The counter clears on any handshake that has tlast=1.

Without the macro defined:
- The HB state, the counter and HB_PERIOD have no effect.
- The link is silent when no records arrive.

## Structure
- md_pkg holds md_record_t, the state enum and the constant MSG_HEARTBEAT = 8'h48. The inbound filter's header type is shared with md_pkg.
- Sub-module md_heartbeat_timer: the idle counter plus threshold compare. It is instantiated only under the macro.

## Test plan
- Single record, tready=1: record {8'h54, 32'h4141504C, 32'h00010000, 32'd100} → beat0 64'h544141504C000000, then beat1 64'h0001000000000064 with tlast=1.
- Back-to-back: 4 records with rec_valid held and tready=1 → 8 consecutive beats, seq 0..3, no tvalid gaps.
- Backpressure: hold tready=0 for 10 cycles during beat0 → tdata stays stable, rec_ready=0 after 2 accepts, no records lost after release.
- Wrap: force seq to 24'hFFFFFF, send 2 records → beat0[23:0] equals FFFFFF, then 000000.
- Reset: assert rst during beat1 → tvalid=0 in the same cycle; the next record goes out with seq 0.
- Heartbeat (macro defined, HB_PERIOD=8): idle 8 cycles → single beat 64'h4800000000000000 with tlast=1. A record arriving in the threshold cycle suppresses the heartbeat.
